// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between icache fills, dcache miss reads and write-queue drains,
// with write-before-read ordering and an icache starvation guard.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 8
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic [31:0] daddr,
    output logic        dwait,
    output logic [31:0] dload,
    input  logic        dqueueWEN,
    input  logic [31:0] wdaddr,
    input  logic [31:0] dstore,
    input  logic        wempty,
    input  logic        full,
    output logic        wqwait,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);
    localparam logic [1:0] RAM_ACCESS = 2'b10;

    typedef enum logic [1:0] {IDLE, IREQ, DREQ, WREQ} state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   store_q, store_d;
    logic          done;

    // ERROR and BUSY both count as not-done; only ACCESS completes a transfer
    assign done = ramstate == RAM_ACCESS;

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        addr_d   = addr_q;
        store_d  = store_q;
        case (state_q)
            IDLE: begin
                if (iREN && starve_q == LIMIT)  state_d = IREQ;
                else if (dqueueWEN && full)     state_d = WREQ;
                else if (dREN && wempty)        state_d = DREQ;
                else if (dqueueWEN)             state_d = WREQ;
                else if (iREN)                  state_d = IREQ;
                starve_d = (state_d == IREQ) ? '0 :
                           (iREN && starve_q != LIMIT) ? starve_q + 1'b1 : starve_q;
                addr_d   = (state_d == IREQ) ? iaddr :
                           (state_d == DREQ) ? daddr :
                           (state_d == WREQ) ? wdaddr : addr_q;
                store_d  = (state_d == WREQ) ? dstore : store_q;
            end
            IREQ:    state_d = (done || !iREN) ? IDLE : IREQ;
            DREQ:    state_d = (done || !dREN) ? IDLE : DREQ;
            default: state_d = done ? IDLE : WREQ;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            starve_q <= '0;
            addr_q   <= '0;
            store_q  <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            addr_q   <= addr_d;
            store_q  <= store_d;
        end
    end

    assign ramREN   = state_q == IREQ || state_q == DREQ;
    assign ramWEN   = state_q == WREQ;
    assign ramaddr  = addr_q;
    assign ramstore = store_q;
    assign iwait    = !(state_q == IREQ && done);
    assign dwait    = !(state_q == DREQ && done);
    assign wqwait   = !(state_q == WREQ && done);
    assign iload    = ramload;
    assign dload    = ramload;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios with a scoreboard of expected completed transfers.
module tb_mem_arbiter;
    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dqueueWEN, wempty, full;
    logic [31:0] iaddr, daddr, wdaddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        iwait, dwait, wqwait, ramREN, ramWEN;
    logic [31:0] iload, dload, ramaddr, ramstore;

    typedef struct packed {
        logic [2:0]  who;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    localparam logic [2:0] OWN_I = 3'b100, OWN_D = 3'b010, OWN_W = 3'b001;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] mem [0:4095];
    int          checks = 0;
    int          failures = 0;

    always #5 CLK = ~CLK;

    mem_arbiter #(.STARVE_LIMIT(2)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .daddr(daddr), .dwait(dwait), .dload(dload),
        .dqueueWEN(dqueueWEN), .wdaddr(wdaddr), .dstore(dstore),
        .wempty(wempty), .full(full), .wqwait(wqwait),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_txn(input logic [2:0] who, input logic [31:0] addr, input logic [31:0] data);
        sb.push_back('{who: who, addr: addr, data: data});
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // memory responder: busy BUSY cycles, errs ERROR cycles, then one ACCESS cycle
    task automatic serve(input int busy, input int errs);
        for (int k = 0; k < busy + errs; k++) begin
            ramstate = (k < busy) ? 2'b01 : 2'b11;
            #1;
            chk("waits_held", 32'({iwait, dwait, wqwait}), 32'h7);
            step();
        end
        ramload = ramREN ? mem[ramaddr[11:0]] : 32'h0;
        if (ramWEN) mem[ramaddr[11:0]] = ramstore;
        ramstate = 2'b10;
        step();
        ramstate = 2'b00;
        ramload  = 32'h0;
    endtask

    // monitor: any wait going low is a completed transfer that must match the scoreboard head
    always @(negedge CLK) begin
        if (nRST && (!iwait || !dwait || !wqwait)) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: waits i/d/wq=%b%b%b with nothing expected at %0t",
                         iwait, dwait, wqwait, $time);
            end else begin
                mon_e = sb.pop_front();
                chk("owner", 32'({!iwait, !dwait, !wqwait}), 32'(mon_e.who));
                chk("done_addr", ramaddr, mon_e.addr);
                chk("done_data", (mon_e.who == OWN_W) ? ramstore :
                                 (mon_e.who == OWN_I) ? iload : dload, mon_e.data);
            end
        end
    end

    initial begin
        for (int a = 0; a < 4096; a++) mem[a] = 32'h0;
        mem[12'h080] = 32'hCAFEF00D;
        mem[12'h200] = 32'h12345678;
        mem[12'h300] = 32'h0BADF00D;
        mem[12'h600] = 32'h66666666;
        nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dqueueWEN = 1'b0;
        wempty = 1'b1; full = 1'b0; ramstate = 2'b00; ramload = 32'h0;
        iaddr = 32'h0; daddr = 32'h0; wdaddr = 32'h0; dstore = 32'h0;
        #1;
        chk("rst_ramREN", 32'(ramREN), 32'h0);
        chk("rst_ramWEN", 32'(ramWEN), 32'h0);
        chk("rst_ramaddr", ramaddr, 32'h0);
        chk("rst_ramstore", ramstore, 32'h0);
        chk("rst_waits", 32'({iwait, dwait, wqwait}), 32'h7);
        @(posedge CLK);
        #3 nRST = 1'b1;
        step();
        chk("idle_no_grant", 32'({ramREN, ramWEN}), 32'h0);

        // dirty write-back must drain before the miss read of the same address
        wempty = 1'b0; dqueueWEN = 1'b1; wdaddr = 32'h100; dstore = 32'hDEADBEEF;
        dREN = 1'b1; daddr = 32'h100;
        expect_txn(OWN_W, 32'h100, 32'hDEADBEEF);
        step();
        chk("wr_first_wen", 32'(ramWEN), 32'h1);
        chk("wr_first_ren", 32'(ramREN), 32'h0);
        chk("wr_first_addr", ramaddr, 32'h100);
        chk("wr_first_store", ramstore, 32'hDEADBEEF);
        wdaddr = 32'h999; dstore = 32'h0;
        #1;
        chk("wr_addr_hold", ramaddr, 32'h100);
        chk("wr_store_hold", ramstore, 32'hDEADBEEF);
        serve(2, 0);
        chk("wr_done_idle", 32'({ramREN, ramWEN}), 32'h0);
        dqueueWEN = 1'b0; wempty = 1'b1;
        expect_txn(OWN_D, 32'h100, 32'hDEADBEEF);
        step();
        chk("rd_after_wr_ren", 32'(ramREN), 32'h1);
        chk("rd_after_wr_addr", ramaddr, 32'h100);
        serve(1, 0);
        dREN = 1'b0;

        // full write queue beats everyone
        full = 1'b1; wempty = 1'b0; dqueueWEN = 1'b1; wdaddr = 32'h140; dstore = 32'h11112222;
        iREN = 1'b1; iaddr = 32'h80; dREN = 1'b1; daddr = 32'h200;
        expect_txn(OWN_W, 32'h140, 32'h11112222);
        step();
        chk("full_wen", 32'(ramWEN), 32'h1);
        chk("full_addr", ramaddr, 32'h140);
        serve(1, 0);
        full = 1'b0; wempty = 1'b1; dqueueWEN = 1'b0; iREN = 1'b0; dREN = 1'b0;
        step();

        // icache abort while BUSY
        iREN = 1'b1; iaddr = 32'h80;
        step();
        chk("abort_grant", 32'(ramREN), 32'h1);
        chk("abort_addr", ramaddr, 32'h80);
        ramstate = 2'b01;
        step();
        chk("abort_still_req", 32'(ramREN), 32'h1);
        chk("abort_iwait", 32'(iwait), 32'h1);
        iREN = 1'b0;
        step();
        chk("abort_ren_off", 32'(ramREN), 32'h0);
        chk("abort_iwait_idle", 32'(iwait), 32'h1);
        ramstate = 2'b00;
        step();

        // starvation: two lost decisions, third goes to icache, then counter is back at zero
        iREN = 1'b1; iaddr = 32'h80; dREN = 1'b1; daddr = 32'h200; wempty = 1'b1;
        expect_txn(OWN_D, 32'h200, 32'h12345678);
        step();
        chk("starve_d1", ramaddr, 32'h200);
        serve(1, 0);
        expect_txn(OWN_D, 32'h200, 32'h12345678);
        step();
        chk("starve_d2", ramaddr, 32'h200);
        serve(1, 0);
        expect_txn(OWN_I, 32'h80, 32'hCAFEF00D);
        step();
        chk("starve_i_ren", 32'(ramREN), 32'h1);
        chk("starve_i_addr", ramaddr, 32'h80);
        serve(1, 0);
        expect_txn(OWN_D, 32'h200, 32'h12345678);
        step();
        chk("starve_cleared", ramaddr, 32'h200);
        serve(0, 0);
        iREN = 1'b0; dREN = 1'b0;
        step();

        // ERROR is not-done: dwait held through it, low for exactly the ACCESS cycle
        dREN = 1'b1; daddr = 32'h300;
        expect_txn(OWN_D, 32'h300, 32'h0BADF00D);
        step();
        chk("err_grant", 32'(ramREN), 32'h1);
        serve(0, 3);
        chk("err_dwait_after", 32'(dwait), 32'h1);
        chk("err_idle", 32'(ramREN), 32'h0);
        dREN = 1'b0;
        step();

        // asynchronous reset in the middle of a write, no replay afterwards
        wempty = 1'b0; dqueueWEN = 1'b1; wdaddr = 32'h500; dstore = 32'h55;
        step();
        chk("rstw_wen", 32'(ramWEN), 32'h1);
        ramstate = 2'b01;
        step();
        #2 nRST = 1'b0;
        #1;
        chk("rstw_wen_off", 32'(ramWEN), 32'h0);
        chk("rstw_ren_off", 32'(ramREN), 32'h0);
        chk("rstw_wqwait", 32'(wqwait), 32'h1);
        chk("rstw_addr", ramaddr, 32'h0);
        chk("rstw_store", ramstore, 32'h0);
        dqueueWEN = 1'b0; wempty = 1'b1; ramstate = 2'b00;
        iREN = 1'b1; iaddr = 32'h600;
        expect_txn(OWN_I, 32'h600, 32'h66666666);
        step();
        chk("rst_held_no_grant", 32'({ramREN, ramWEN}), 32'h0);
        #2 nRST = 1'b1;
        step();
        chk("post_rst_grant", 32'(ramREN), 32'h1);
        chk("post_rst_addr", ramaddr, 32'h600);
        serve(0, 0);
        iREN = 1'b0;
        repeat (2) step();
        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
